data_ram_resp: RTL and testbench

DATA_RAM_RESP -- requirements
Module: data_ram_resp

---
 rtl/data_ram_resp_if.sv | 32 +++
 rtl/data_ram_resp.sv | 125 ++++++++++++
 tb/tb_data_ram_resp.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/data_ram_resp_if.sv
// rtl/data_ram_resp_if.sv - data-memory access bus between the memory-access stage and data_ram_resp
//
// Signals:
//   dm_addr  [31:0] byte address from the initiator
//   dm_wen   [3:0]  byte-lane write enables (bit i -> dm_wdata[8i+7:8i])
//   dm_wdata [31:0] lane-aligned write data
//   dm_rdata [31:0] registered read data, one-cycle latency
//   dm_ready        RAM accepts accesses
// Modports: master = initiator side, slave = RAM side.
interface data_ram_resp_if;
    logic [31:0] dm_addr;
    logic [3:0]  dm_wen;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ready;

    modport master (
        output dm_addr,
        output dm_wen,
        output dm_wdata,
        input  dm_rdata,
        input  dm_ready
    );

    modport slave (
        input  dm_addr,
        input  dm_wen,
        input  dm_wdata,
        output dm_rdata,
        output dm_ready
    );
endinterface

// File: rtl/data_ram_resp.sv
// rtl/data_ram_resp.sv - word-addressed data RAM with byte-lane writes, read-first data port and debug read port
//
// Parameter:
//   ADDR_W     log2 of RAM depth in 32-bit words (default 8 -> 256 words)
// Ports:
//   clk        single clock, all state on rising edge
//   reset      synchronous, active-high
//   bus        data_ram_resp_if.slave (dm_addr, dm_wen, dm_wdata, dm_rdata, dm_ready)
//   test_addr  byte address for the display/debug read port
//   test_data  registered debug read data, one-cycle latency
// Optional feature:
//   DM_CLEAR_EN  when defined, reset starts a CLEAR/READY sequencer that zeroes
//                every word (2^ADDR_W cycles) with dm_ready low meanwhile.
module data_ram_resp #(
    parameter int ADDR_W = 8
) (
    input  logic            clk,
    input  logic            reset,
    data_ram_resp_if.slave  bus,
    input  logic [31:0]     test_addr,
    output logic [31:0]     test_data
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] dm_idx;
    logic [ADDR_W-1:0] test_idx;
    logic              ready;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_idx;
    logic [31:0]       rdata_q;
    logic [31:0]       test_q;

    // Byte offset and upper address bits are dropped, so upper addresses alias.
    assign dm_idx   = bus.dm_addr[ADDR_W+1:2];
    assign test_idx = test_addr[ADDR_W+1:2];

    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.dm_addr[31:ADDR_W+2], bus.dm_addr[1:0],
                                test_addr[31:ADDR_W+2], test_addr[1:0]};

`ifdef DM_CLEAR_EN
    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] cnt_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // One word zeroed per CLEAR cycle; the last word's write happens on the
    // same edge that moves to READY.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        clr_we     = 1'b0;
        case (state)
            CLEAR: begin
                clr_we   = 1'b1;
                cnt_next = cnt + 1'b1;
                if (cnt == '1) begin
                    state_next = READY;
                end
            end
            READY: begin
                clr_we = 1'b0;
            end
            default: begin
                state_next = CLEAR;
                cnt_next   = '0;
            end
        endcase
    end

    assign ready   = (state == READY);
    assign clr_idx = cnt;
`else
    assign ready   = 1'b1;
    assign clr_we  = 1'b0;
    assign clr_idx = '0;
`endif

    assign bus.dm_ready = ready;

    // Memory contents are not reset; writes are simply blocked while reset is high.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (clr_we) begin
                mem[clr_idx] <= 32'd0;
            end else if (ready) begin
                for (int i = 0; i < 4; i++) begin
                    if (bus.dm_wen[i]) begin
                        mem[dm_idx][8*i +: 8] <= bus.dm_wdata[8*i +: 8];
                    end
                end
            end
        end
    end

    // Non-blocking reads of mem sample the pre-write word (read-first).
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= 32'd0;
            test_q  <= 32'd0;
        end else begin
            rdata_q <= ready ? mem[dm_idx] : 32'd0;
            test_q  <= mem[test_idx];
        end
    end

    assign bus.dm_rdata = rdata_q;
    assign test_data    = test_q;
endmodule

// File: tb/tb_data_ram_resp.sv
// tb/tb_data_ram_resp.sv - table-driven self-checking bench for data_ram_resp
module tb_data_ram_resp;
    logic        clk;
    logic        reset;
    logic [31:0] test_addr;
    logic [31:0] test_data;

    int n_vec;
    int n_bad;

    data_ram_resp_if bus ();

    data_ram_resp #(.ADDR_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.slave),
        .test_addr (test_addr),
        .test_data (test_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  wen;
        logic [31:0] wdata;
        logic [31:0] taddr;
        logic [31:0] exp_rdata;
        logic [31:0] exp_tdata;
    } vec_t;

    vec_t vecs [14];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d, input logic [31:0] t);
        bus.dm_addr  = a;
        bus.dm_wen   = w;
        bus.dm_wdata = d;
        test_addr    = t;
    endtask

    // Waits for dm_ready; returns number of ticks taken, or -1 on timeout.
    task automatic wait_ready(output int n);
        n = 0;
        while (bus.dm_ready !== 1'b1 && n < 1000) begin
            tick();
            n++;
        end
        if (bus.dm_ready !== 1'b1) n = -1;
    endtask

    initial begin
        int          n;
        int          bad;
        logic [31:0] zero_addrs [7];
        logic [31:0] exp33;

        n_vec = 0;
        n_bad = 0;

        // addr, wen, wdata, taddr, exp_rdata, exp_tdata
        vecs[0]  = '{32'h10,       4'hF, 32'h12345678, 32'h10,  32'h0,        32'h0};
        vecs[1]  = '{32'h10,       4'h0, 32'hFFFFFFFF, 32'h10,  32'h12345678, 32'h12345678};
        vecs[2]  = '{32'h10,       4'h4, 32'h00AB0000, 32'h14,  32'h12345678, 32'h0};
        vecs[3]  = '{32'h10,       4'h0, 32'hFFFFFFFF, 32'h10,  32'h12AB5678, 32'h12AB5678};
        vecs[4]  = '{32'h10,       4'h0, 32'hFFFFFFFF, 32'h20,  32'h12AB5678, 32'h0};
        vecs[5]  = '{32'h20,       4'hF, 32'hDEADBEEF, 32'h20,  32'h0,        32'h0};
        vecs[6]  = '{32'h13,       4'h0, 32'h0,        32'h20,  32'h12AB5678, 32'hDEADBEEF};
        vecs[7]  = '{32'h400,      4'hF, 32'hCAFEF00D, 32'h0,   32'h0,        32'h0};
        vecs[8]  = '{32'h0,        4'h0, 32'h0,        32'h400, 32'hCAFEF00D, 32'hCAFEF00D};
        vecs[9]  = '{32'h4,        4'h1, 32'h112233AA, 32'h10,  32'h0,        32'h12AB5678};
        vecs[10] = '{32'h4,        4'h8, 32'h55000000, 32'h4,   32'h000000AA, 32'h000000AA};
        vecs[11] = '{32'h4,        4'h0, 32'h0,        32'h0,   32'h550000AA, 32'hCAFEF00D};
        vecs[12] = '{32'hFFFFFFFC, 4'hF, 32'hA5A5A5A5, 32'h3FC, 32'h0,        32'h0};
        vecs[13] = '{32'h3FC,      4'h0, 32'h0,        32'hFFC, 32'hA5A5A5A5, 32'hA5A5A5A5};

        zero_addrs[0] = 32'h0;
        zero_addrs[1] = 32'h4;
        zero_addrs[2] = 32'h10;
        zero_addrs[3] = 32'h14;
        zero_addrs[4] = 32'h20;
        zero_addrs[5] = 32'h3FC;
        zero_addrs[6] = 32'h30;

        // Reset with a write attempt on the reset cycle.
        reset = 1'b1;
        drive(32'h10, 4'hF, 32'hFFFFFFFF, 32'h10);
        tick();
        check("reset_rdata", bus.dm_rdata, 32'h0);
        check("reset_tdata", test_data, 32'h0);
        reset = 1'b0;
        drive(32'h0, 4'h0, 32'h0, 32'h0);
`ifdef DM_CLEAR_EN
        wait_ready(n);
        check("init_clear_done", (n < 0) ? 32'hFFFFFFFF : 32'h1, 32'h1);
`else
        check("ready_after_reset", {31'd0, bus.dm_ready}, 32'h1);
`endif

        // Known contents for words read before they are written.
        for (int i = 0; i < 7; i++) begin
            drive(zero_addrs[i], 4'hF, 32'h0, 32'h0);
            tick();
        end

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].addr, vecs[i].wen, vecs[i].wdata, vecs[i].taddr);
            tick();
            check($sformatf("vec%0d_rdata", i), bus.dm_rdata, vecs[i].exp_rdata);
            check($sformatf("vec%0d_tdata", i), test_data, vecs[i].exp_tdata);
            check($sformatf("vec%0d_ready", i), {31'd0, bus.dm_ready}, 32'h1);
        end

        // Reset during back-to-back writes: the reset-cycle write must be lost.
        drive(32'h30, 4'hF, 32'h11111111, 32'h30);
        tick();
        drive(32'h30, 4'hF, 32'h22222222, 32'h30);
        reset = 1'b1;
        tick();
        check("rst_b2b_rdata", bus.dm_rdata, 32'h0);
        check("rst_b2b_tdata", test_data, 32'h0);
        reset = 1'b0;
        drive(32'h30, 4'h0, 32'h0, 32'h30);
`ifdef DM_CLEAR_EN
        wait_ready(n);
        exp33 = 32'h0;
`else
        exp33 = 32'h11111111;
`endif
        tick();
        check("rst_b2b_readback", bus.dm_rdata, exp33);
        check("rst_b2b_test_readback", test_data, exp33);

`ifdef DM_CLEAR_EN
        // Preload nonzero, then a full clear with writes attempted throughout.
        drive(32'h10, 4'hF, 32'h5555AAAA, 32'h0);
        tick();
        drive(32'h3FC, 4'hF, 32'h77777777, 32'h0);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(32'h10, 4'hF, 32'hFFFFFFFF, 32'h10);
        n = 0;
        bad = 0;
        while (bus.dm_ready !== 1'b1 && n < 1000) begin
            tick();
            n++;
            if (bus.dm_ready !== 1'b1 && bus.dm_rdata !== 32'h0) bad++;
        end
        drive(32'h0, 4'h0, 32'h0, 32'h0);
        check("clear_cycles", n, 32'd256);
        check("clear_rdata_zero", bad, 32'd0);

        // Reset 100 cycles into CLEAR restarts the full count.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (100) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n = 0;
        while (bus.dm_ready !== 1'b1 && n < 1000) begin
            tick();
            n++;
        end
        check("clear_restart_cycles", n, 32'd256);

        bad = 0;
        for (int w = 0; w < 256; w++) begin
            drive(w * 4, 4'h0, 32'h0, w * 4);
            tick();
            if (bus.dm_rdata !== 32'h0 || test_data !== 32'h0) bad++;
        end
        check("clear_all_zero", bad, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
